// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the register file write port among NREQ requesters
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_num,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               stall,
    output logic [NREQ-1:0]    ack,
    output logic               write,
    output logic [AW-1:0]      writenum,
    output logic [DW-1:0]      data_in,
    output logic               busy,
    output logic [1:0]         last_gnt
);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t          state;
    logic [NREQ-1:0] eff;
    logic [1:0]      win, idx;
    logic            found;
    assign eff  = req & ~ack;
    assign busy = (state == WRITE);
    always_comb begin
        win   = last_gnt;
        idx   = last_gnt;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = 2'((int'(last_gnt) + i) % NREQ);
            if (!found && eff[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            write    <= 1'b0;
            ack      <= '0;
            writenum <= '0;
            data_in  <= '0;
            last_gnt <= 2'(NREQ - 1);
        end else if (!stall && found) begin
            state    <= WRITE;
            write    <= 1'b1;
            ack      <= NREQ'(1) << win;
            writenum <= req_num[win*AW +: AW];
            data_in  <= req_data[win*DW +: DW];
            last_gnt <= win;
        end else begin
            state <= IDLE;
            write <= 1'b0;
            ack   <= '0;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed checks of grant order, latching, stall and reset
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_num = '0;
    logic [63:0] req_data = '0;
    logic        stall = 1'b0;
    logic [3:0]  ack;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        busy;
    logic [1:0]  last_gnt;
    int tests = 0;
    int fails = 0;

    regfile_wr_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_num(req_num),
        .req_data(req_data), .stall(stall), .ack(ack), .write(write),
        .writenum(writenum), .data_in(data_in), .busy(busy), .last_gnt(last_gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset mid-write
        #12 reset_n = 1'b1;
        step();
        req = 4'b0001;
        req_num[2:0] = 3'd6;
        req_data[15:0] = 16'hBEEF;
        step();
        chk("pre_rst_write", write, 1);
        chk("pre_rst_num", writenum, 6);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_write", write, 0);
        chk("rst_ack", ack, 0);
        chk("rst_num", writenum, 0);
        chk("rst_data", data_in, 0);
        chk("rst_busy", busy, 0);
        req = '0;
        #1 reset_n = 1'b1;
        chk("rst_last_gnt", last_gnt, 3);
        // single request
        step();
        req = 4'b0100;
        req_num[8:6] = 3'd5;
        req_data[47:32] = 16'h00A5;
        step();
        chk("single_write", write, 1);
        chk("single_num", writenum, 5);
        chk("single_data", data_in, 16'h00A5);
        chk("single_ack", ack, 4'b0100);
        chk("single_last", last_gnt, 2);
        req = '0;
        step();
        chk("single_done", write, 0);
        chk("single_hold", writenum, 5);
        // round robin after a fresh reset
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_num[i*3 +: 3] = 3'(i + 1);
            req_data[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rr_ack%0d", i), ack, 32'(1 << (i % 4)));
            chk($sformatf("rr_wr%0d", i), write, 1);
            chk($sformatf("rr_num%0d", i), writenum, 32'(i % 4 + 1));
            chk($sformatf("rr_data%0d", i), data_in, 32'h0000A000 + 32'(i % 4));
        end
        req = '0;
        step();
        chk("rr_done", write, 0);
        // requester 1 holds one cycle past ack alongside requester 3
        req = 4'b1010;
        step();
        chk("dbl_ack1", ack, 4'b0010);
        step();
        chk("dbl_ack3", ack, 4'b1000);
        req = '0;
        step();
        chk("dbl_idle", write, 0);
        chk("dbl_idle_ack", ack, 0);
        // requester 1 alone holding past its ack
        req = 4'b0010;
        step();
        chk("solo_ack", ack, 4'b0010);
        step();
        chk("solo_no_rewrite", write, 0);
        chk("solo_no_ack", ack, 0);
        req = '0;
        // stall during requester 0 write
        req = 4'b0001;
        step();
        chk("stall_ack0", ack, 4'b0001);
        chk("stall_wr0", write, 1);
        stall = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_hold%0d", i), write, 0);
        end
        stall = 1'b0;
        step();
        chk("stall_gnt2", ack, 4'b0100);
        chk("stall_wr2", write, 1);
        req = '0;
        step();
        chk("stall_done", write, 0);
        // request and stall rise together
        req = 4'b0010;
        stall = 1'b1;
        step();
        chk("rise_blocked", write, 0);
        stall = 1'b0;
        step();
        chk("rise_gnt", ack, 4'b0010);
        req = '0;
        step();
        // data latched at grant
        req = 4'b0001;
        req_data[15:0] = 16'h1234;
        step();
        req_data[15:0] = 16'hFFFF;
        req = '0;
        #2;
        chk("latch_data", data_in, 16'h1234);
        chk("latch_write", write, 1);
        step();
        chk("latch_done", write, 0);
        chk("latch_hold", data_in, 16'h1234);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
